// File: rtl/pellet_map.sv
// -----------------------------------------------------------------------------
// pellet_map
// Pellet occupancy store for the pellet renderer. The playfield is a 32x32 grid
// of 16x16-pixel cells, one bit per cell (1 = pellet present).
//
// At reset or restart the layout is copied row by row from the maze ROM. During
// play the renderer reads cells with one cycle of latency, and cells the player
// eats are cleared. The block counts the pellets left and reports when the level
// has been cleared.
//
// Ports
//   clk           in   1      system clock, all state on rising edge
//   reset         in   1      synchronous, active-low reset (0 = reset)
//   restart       in   1      one-cycle pulse: reload the layout (new level)
//   init_row      out  5      maze ROM row address while loading
//   init_bits     in   32     maze ROM row data for init_row; bit n = column n
//   rd_x          in   5      renderer read column
//   rd_y          in   5      renderer read row
//   rd_dout       out  1      pellet bit at (rd_y, rd_x) from the previous cycle
//   eat_req       in   1      one-cycle pulse: player centred on (eat_y, eat_x)
//   eat_x         in   5      eat column
//   eat_y         in   5      eat row
//   pellet_eaten  out  1      one-cycle pulse: eat_req hit a present pellet
//   remaining     out  CNT_W  pellets left on the map
//   level_clear   out  1      high while the level is cleared
//   ready         out  1      high while the level is being played
// -----------------------------------------------------------------------------
module pellet_map #(
    parameter int ROWS  = 32,
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    output logic [4:0]       init_row,
    input  logic [31:0]      init_bits,
    input  logic [4:0]       rd_x,
    input  logic [4:0]       rd_y,
    output logic             rd_dout,
    input  logic             eat_req,
    input  logic [4:0]       eat_x,
    input  logic [4:0]       eat_y,
    output logic             pellet_eaten,
    output logic [CNT_W-1:0] remaining,
    output logic             level_clear,
    output logic             ready
);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_CLEARED = 2'd2
    } state_t;

    localparam logic [4:0]       LAST_ROW = 5'(ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Number of set bits in a 32-bit ROM row (0..32).
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    // State and storage
    state_t           state_q;
    logic [4:0]       row_q;
    logic [CNT_W-1:0] remaining_q;
    logic [31:0]      map_q [ROWS];

    // Registered outputs
    logic             rd_dout_q;
    logic             pellet_eaten_q;
    logic             level_clear_q;
    logic             ready_q;

    // Combinational helpers
    logic [5:0]       load_pop_s;
    logic [CNT_W-1:0] load_sum_s;
    logic             last_row_s;
    logic             rd_bit_s;
    logic             eat_hit_s;

    // Load-pass arithmetic and map lookups for the read and eat ports.
    always_comb begin
        load_pop_s = popcount32(init_bits);
        load_sum_s = remaining_q + CNT_W'(load_pop_s);
        last_row_s = (row_q == LAST_ROW);
        rd_bit_s   = map_q[rd_y][rd_x];
        // Gating on the stored bit is what keeps the counter from underflowing.
        eat_hit_s  = eat_req & map_q[eat_y][eat_x];
    end

    // Map FSM: load pass, play with eat/read service, cleared level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_LOAD;
            row_q          <= 5'd0;
            remaining_q    <= CNT_ZERO;
            rd_dout_q      <= 1'b0;
            pellet_eaten_q <= 1'b0;
            level_clear_q  <= 1'b0;
            ready_q        <= 1'b0;
        end else if (restart) begin
            // A restart in any state, including mid-load, starts a fresh pass.
            state_q        <= ST_LOAD;
            row_q          <= 5'd0;
            remaining_q    <= CNT_ZERO;
            rd_dout_q      <= 1'b0;
            pellet_eaten_q <= 1'b0;
            level_clear_q  <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    map_q[row_q]   <= init_bits;
                    remaining_q    <= load_sum_s;
                    row_q          <= row_q + 5'd1;
                    rd_dout_q      <= 1'b0;
                    pellet_eaten_q <= 1'b0;
                    if (last_row_s) begin
                        // The final row's popcount is included in the decision.
                        if (load_sum_s != CNT_ZERO) begin
                            state_q       <= ST_PLAY;
                            ready_q       <= 1'b1;
                            level_clear_q <= 1'b0;
                        end else begin
                            state_q       <= ST_CLEARED;
                            ready_q       <= 1'b0;
                            level_clear_q <= 1'b1;
                        end
                    end else begin
                        state_q       <= ST_LOAD;
                        ready_q       <= 1'b0;
                        level_clear_q <= 1'b0;
                    end
                end

                ST_PLAY: begin
                    // Read samples the map before any same-cycle eat clears it.
                    rd_dout_q <= rd_bit_s;
                    if (eat_hit_s) begin
                        map_q[eat_y][eat_x] <= 1'b0;
                        remaining_q         <= remaining_q - CNT_ONE;
                        pellet_eaten_q      <= 1'b1;
                        if (remaining_q == CNT_ONE) begin
                            state_q       <= ST_CLEARED;
                            ready_q       <= 1'b0;
                            level_clear_q <= 1'b1;
                        end else begin
                            state_q       <= ST_PLAY;
                            ready_q       <= 1'b1;
                            level_clear_q <= 1'b0;
                        end
                    end else begin
                        state_q        <= ST_PLAY;
                        pellet_eaten_q <= 1'b0;
                        ready_q        <= 1'b1;
                        level_clear_q  <= 1'b0;
                    end
                end

                ST_CLEARED: begin
                    // Eat requests are ignored. Reads are still served.
                    state_q        <= ST_CLEARED;
                    rd_dout_q      <= rd_bit_s;
                    pellet_eaten_q <= 1'b0;
                    ready_q        <= 1'b0;
                    level_clear_q  <= 1'b1;
                end

                default: begin
                    state_q        <= ST_LOAD;
                    row_q          <= 5'd0;
                    remaining_q    <= CNT_ZERO;
                    rd_dout_q      <= 1'b0;
                    pellet_eaten_q <= 1'b0;
                    level_clear_q  <= 1'b0;
                    ready_q        <= 1'b0;
                end
            endcase
        end
    end

    assign init_row     = row_q;
    assign rd_dout      = rd_dout_q;
    assign pellet_eaten = pellet_eaten_q;
    assign remaining    = remaining_q;
    assign level_clear  = level_clear_q;
    assign ready        = ready_q;

endmodule

// File: tb/tb_pellet_map.sv
// -----------------------------------------------------------------------------
// tb_pellet_map
// Directed bench for pellet_map. A small ROM array feeds init_bits from
// init_row. Expected values are hand-computed from each ROM layout.
// -----------------------------------------------------------------------------
module tb_pellet_map;

    logic        clk;
    logic        reset;
    logic        restart;
    logic [4:0]  init_row;
    logic [31:0] init_bits;
    logic [4:0]  rd_x;
    logic [4:0]  rd_y;
    logic        rd_dout;
    logic        eat_req;
    logic [4:0]  eat_x;
    logic [4:0]  eat_y;
    logic        pellet_eaten;
    logic [10:0] remaining;
    logic        level_clear;
    logic        ready;

    logic [31:0] rom [32];

    int checks;
    int failures;

    pellet_map #(.ROWS(32), .CNT_W(11)) dut (
        .clk          (clk),
        .reset        (reset),
        .restart      (restart),
        .init_row     (init_row),
        .init_bits    (init_bits),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_dout      (rd_dout),
        .eat_req      (eat_req),
        .eat_x        (eat_x),
        .eat_y        (eat_y),
        .pellet_eaten (pellet_eaten),
        .remaining    (remaining),
        .level_clear  (level_clear),
        .ready        (ready)
    );

    assign init_bits = rom[init_row];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_fill(input logic [31:0] v);
        for (int i = 0; i < 32; i++) rom[i] = v;
    endtask

    // Full 32-cycle load pass, starting with the row counter at 0.
    task automatic run_load();
        for (int i = 0; i < 32; i++) begin
            check_eq("load_init_row", {27'd0, init_row}, i);
            check_eq("load_ready", {31'd0, ready}, 32'd0);
            check_eq("load_rd_dout", {31'd0, rd_dout}, 32'd0);
            check_eq("load_eaten", {31'd0, pellet_eaten}, 32'd0);
            tick();
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        restart  = 1'b0;
        rd_x     = 5'd0;
        rd_y     = 5'd0;
        eat_req  = 1'b0;
        eat_x    = 5'd0;
        eat_y    = 5'd0;
        rom_fill(32'hFFFF_FFFF);

        // Reset state
        tick();
        tick();
        check_eq("rst_init_row", {27'd0, init_row}, 32'd0);
        check_eq("rst_remaining", {21'd0, remaining}, 32'd0);
        check_eq("rst_ready", {31'd0, ready}, 32'd0);
        check_eq("rst_level_clear", {31'd0, level_clear}, 32'd0);
        check_eq("rst_eaten", {31'd0, pellet_eaten}, 32'd0);
        check_eq("rst_rd_dout", {31'd0, rd_dout}, 32'd0);

        // All-ones ROM: 32 load cycles, then full map
        reset = 1'b1;
        run_load();
        check_eq("full_ready", {31'd0, ready}, 32'd1);
        check_eq("full_remaining", {21'd0, remaining}, 32'd1024);
        check_eq("full_level_clear", {31'd0, level_clear}, 32'd0);
        rd_y = 5'd31; rd_x = 5'd31;
        tick();
        check_eq("full_rd_31_31", {31'd0, rd_dout}, 32'd1);

        // Empty ROM: load goes straight to cleared
        rom_fill(32'h0000_0000);
        do_restart();
        check_eq("rs_remaining0", {21'd0, remaining}, 32'd0);
        run_load();
        check_eq("empty_ready", {31'd0, ready}, 32'd0);
        check_eq("empty_level_clear", {31'd0, level_clear}, 32'd1);
        check_eq("empty_remaining", {21'd0, remaining}, 32'd0);

        // Single pellet at row 5, column 4
        rom[5] = 32'h0000_0010;
        do_restart();
        run_load();
        check_eq("one_remaining", {21'd0, remaining}, 32'd1);
        check_eq("one_ready", {31'd0, ready}, 32'd1);
        rd_y = 5'd5; rd_x = 5'd4;
        tick();
        check_eq("one_rd_5_4", {31'd0, rd_dout}, 32'd1);
        rd_x = 5'd3;
        tick();
        check_eq("one_rd_5_3", {31'd0, rd_dout}, 32'd0);
        eat_req = 1'b1; eat_y = 5'd5; eat_x = 5'd4;
        tick();
        eat_req = 1'b0;
        check_eq("last_eat_pulse", {31'd0, pellet_eaten}, 32'd1);
        check_eq("last_eat_remaining", {21'd0, remaining}, 32'd0);
        check_eq("last_eat_level_clear", {31'd0, level_clear}, 32'd1);
        check_eq("last_eat_ready", {31'd0, ready}, 32'd0);
        rd_x = 5'd4;
        tick();
        check_eq("clr_eaten_low", {31'd0, pellet_eaten}, 32'd0);
        check_eq("clr_level_clear", {31'd0, level_clear}, 32'd1);
        check_eq("clr_rd_5_4", {31'd0, rd_dout}, 32'd0);

        // Multi-pellet map: (0,0), (7,7), (31,31), row 10 columns 0..3 -> 7 pellets
        rom_fill(32'h0000_0000);
        rom[0]  = 32'h0000_0001;
        rom[7]  = 32'h0000_0080;
        rom[10] = 32'h0000_000F;
        rom[31] = 32'h8000_0000;
        do_restart();
        run_load();
        check_eq("multi_remaining", {21'd0, remaining}, 32'd7);
        rd_y = 5'd0; rd_x = 5'd0;
        tick();
        check_eq("multi_rd_0_0", {31'd0, rd_dout}, 32'd1);
        rd_y = 5'd31; rd_x = 5'd31;
        tick();
        check_eq("multi_rd_31_31", {31'd0, rd_dout}, 32'd1);
        rd_y = 5'd31; rd_x = 5'd30;
        tick();
        check_eq("multi_rd_31_30", {31'd0, rd_dout}, 32'd0);

        // Read and eat the same cell in the same cycle
        rd_y = 5'd7; rd_x = 5'd7;
        eat_req = 1'b1; eat_y = 5'd7; eat_x = 5'd7;
        tick();
        eat_req = 1'b0;
        check_eq("same_rd_pre_eat", {31'd0, rd_dout}, 32'd1);
        check_eq("same_eat_pulse", {31'd0, pellet_eaten}, 32'd1);
        check_eq("same_remaining", {21'd0, remaining}, 32'd6);
        tick();
        check_eq("same_rd_post_eat", {31'd0, rd_dout}, 32'd0);
        check_eq("same_pulse_1cyc", {31'd0, pellet_eaten}, 32'd0);

        // Repeat eat on the now-empty cell: no pulse, no count change
        eat_req = 1'b1;
        tick();
        eat_req = 1'b0;
        check_eq("repeat_no_pulse", {31'd0, pellet_eaten}, 32'd0);
        check_eq("repeat_remaining", {21'd0, remaining}, 32'd6);
        check_eq("repeat_ready", {31'd0, ready}, 32'd1);

        // Two more eats in row 10
        eat_req = 1'b1; eat_y = 5'd10; eat_x = 5'd1;
        tick();
        check_eq("eat_10_1_remaining", {21'd0, remaining}, 32'd5);
        eat_x = 5'd2;
        tick();
        eat_req = 1'b0;
        check_eq("eat_10_2_remaining", {21'd0, remaining}, 32'd4);
        check_eq("eat_10_2_pulse", {31'd0, pellet_eaten}, 32'd1);

        // Restart mid-play restores the ROM count; eats during load are ignored
        do_restart();
        check_eq("rs_play_ready", {31'd0, ready}, 32'd0);
        check_eq("rs_play_remaining", {21'd0, remaining}, 32'd0);
        eat_req = 1'b1; eat_y = 5'd0; eat_x = 5'd0;
        rd_y = 5'd0; rd_x = 5'd0;
        run_load();
        eat_req = 1'b0;
        check_eq("reload_remaining", {21'd0, remaining}, 32'd7);
        check_eq("reload_ready", {31'd0, ready}, 32'd1);
        rd_y = 5'd7; rd_x = 5'd7;
        tick();
        check_eq("reload_rd_7_7", {31'd0, rd_dout}, 32'd1);

        // Reset at load row 10 abandons the pass
        do_restart();
        for (int i = 0; i < 10; i++) begin
            check_eq("part_init_row", {27'd0, init_row}, i);
            tick();
        end
        check_eq("part_row10", {27'd0, init_row}, 32'd10);
        check_eq("part_remaining", {21'd0, remaining}, 32'd2);
        reset = 1'b0;
        tick();
        check_eq("midrst_init_row", {27'd0, init_row}, 32'd0);
        check_eq("midrst_remaining", {21'd0, remaining}, 32'd0);
        reset = 1'b1;
        run_load();
        check_eq("post_rst_remaining", {21'd0, remaining}, 32'd7);
        check_eq("post_rst_ready", {31'd0, ready}, 32'd1);
        check_eq("post_rst_level_clear", {31'd0, level_clear}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
